i2c_req_scheduler: RTL

I2C_REQ_SCHEDULER -- requirements
Module: i2c_req_scheduler

---
 rtl/i2c_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/i2c_req_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared constants for the I2C request scheduler: field widths, the default
// watchdog limit and the scheduler state encodings. Also provides the
// round-robin pointer advance helper.
// Optional feature macro used by the scheduler: I2C_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

   localparam int unsigned I2C_ADDR_W      = 7;
   localparam int unsigned I2C_DATA_W      = 8;
   localparam int unsigned TIMEOUT_CYC_DEF = 1024;

   // Scheduler state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Next round-robin start position after requester g was served
   function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin winner selection. The search starts at ptr and
// wraps from NREQ-1 back to 0; the first requester found wins.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IW    highest-priority position for this selection
//   grant out NREQ  one-hot winner (all zero when no request)
//   idx   out IW    binary index of the winner
//   any   out 1     at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      int unsigned pos;
      logic [IW-1:0] c;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = 0;
      c     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         // Walk positions ptr, ptr+1, ... modulo NREQ without a divider
         pos = 32'(ptr) + i;
         if (pos >= NREQ) begin
            pos = pos - NREQ;
         end
         c = IW'(pos);
         if (!any && req[c]) begin
            any      = 1'b1;
            grant[c] = 1'b1;
            idx      = c;
         end
      end
   end

endmodule

// File: rtl/i2c_req_scheduler.sv
// ---------------------------------------------------------------------------
// i2c_req_scheduler
// Arbitrates NREQ requesters onto a single I2C master. One transaction is in
// flight at a time: IDLE (select + accept) -> ISSUE (strobe master when not
// busy) -> WAIT (until m_done) -> RESP (completion pulse) -> IDLE.
// Optional macro I2C_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYC
// cycles that aborts the master and completes with rsp_err=1.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_rw   in  NREQ     request level / direction (1 = read)
//   req_addr           in  NREQ*7   packed slave addresses
//   req_reg/req_wdata  in  NREQ*8   packed register indices / write bytes
//   req_ready          out NREQ     one-hot accept pulse
//   rsp_valid          out NREQ     one-hot completion pulse
//   rsp_rdata/rsp_err  out 8/1      response data / NACK-or-timeout flag
//   m_start            out 1        command strobe to the master
//   m_addr/m_rw/m_reg/m_wdata  out  latched command fields
//   m_busy/m_done/m_nack/m_rdata in master status and read byte
//   m_abort            out 1        abort pulse (watchdog build only)
// ---------------------------------------------------------------------------
module i2c_req_scheduler
   import i2c_arb_pkg::*;
#(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*I2C_ADDR_W-1:0] req_addr,
   input  logic [NREQ-1:0]            req_rw,
   input  logic [NREQ*I2C_DATA_W-1:0] req_reg,
   input  logic [NREQ*I2C_DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]            req_ready,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [I2C_DATA_W-1:0]      rsp_rdata,
   output logic                       rsp_err,
   output logic                       m_start,
   output logic [I2C_ADDR_W-1:0]      m_addr,
   output logic                       m_rw,
   output logic [I2C_DATA_W-1:0]      m_reg,
   output logic [I2C_DATA_W-1:0]      m_wdata,
   input  logic                       m_busy,
   input  logic                       m_done,
   input  logic                       m_nack,
   input  logic [I2C_DATA_W-1:0]      m_rdata,
   output logic                       m_abort
);

   localparam int unsigned IW = $clog2(NREQ);

   logic [1:0]      state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   gidx;
   logic [NREQ-1:0] arb_grant;
   logic [IW-1:0]   arb_idx;
   logic            arb_any;
   logic            tmo_hit;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // Accept is decoded combinationally in IDLE; gating with rst_n keeps the
   // pulse low while reset is held even if requesters are still asserting.
   assign req_ready = (rst_n && state == ST_IDLE) ? arb_grant : '0;
   assign rsp_valid = (state == ST_RESP) ? (NREQ'(1) << gidx) : '0;
   assign m_start   = (state == ST_ISSUE) && !m_busy;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] tmo_cnt;

   // First WAIT cycle sees count 0, so the limit is hit on WAIT cycle
   // TIMEOUT_CYC. A m_done arriving in that same cycle takes priority.
   assign tmo_hit = (state == ST_WAIT) && !m_done && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
   assign m_abort = tmo_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (m_start) begin
         tmo_cnt <= '0;
      end else if (state == ST_WAIT) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign m_abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         gidx      <= '0;
         m_addr    <= '0;
         m_rw      <= 1'b0;
         m_reg     <= '0;
         m_wdata   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_any) begin
                  gidx    <= arb_idx;
                  m_addr  <= req_addr[arb_idx*I2C_ADDR_W +: I2C_ADDR_W];
                  m_rw    <= req_rw[arb_idx];
                  m_reg   <= req_reg[arb_idx*I2C_DATA_W +: I2C_DATA_W];
                  m_wdata <= req_wdata[arb_idx*I2C_DATA_W +: I2C_DATA_W];
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!m_busy) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (m_done) begin
                  // A NACKed read carries no valid data
                  rsp_err   <= m_nack;
                  rsp_rdata <= (m_rw && !m_nack) ? m_rdata : '0;
                  state     <= ST_RESP;
               end else if (tmo_hit) begin
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               ptr   <= IW'(rr_next(32'(gidx), NREQ));
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
